// File: rtl/xrst_settlement_ingest_pkg.sv
`default_nettype none
// ============================================================================
// Module      : xrst_pkg
// Description : Shared types and constants for the XRST settlement ingest
//               block: FSM states, status codes, packet/frame field offsets
//               and the per-actor ledger entry.
// Revision    : 1.0 - initial release
// ============================================================================
package xrst_pkg;

  // Packet geometry: only the low 288 bits carry information.
  localparam int c_PKT_W       = 4096;
  localparam int c_STORE_W     = 288;
  localparam int c_WORD_W      = 32;
  localparam int c_CHK_WORDS   = 8;

  // Packet field offsets (LSB positions, all fields used here are 32 bits).
  localparam int c_SID_LSB     = 0;
  localparam int c_ACTOR_LSB   = 64;
  localparam int c_PENALTY_LSB = 96;
  localparam int c_CREDIT_LSB  = 128;
  localparam int c_NET_LSB     = 160;
  localparam int c_PROOF_LSB   = 256;

  // Acknowledgement frame field offsets.
  localparam int c_FR_SID_LSB    = 0;
  localparam int c_FR_ACTOR_LSB  = 32;
  localparam int c_FR_STATUS_LSB = 64;
  localparam int c_FR_BAL_LSB    = 72;

  // Packet processing status codes carried in the ack frame.
  localparam logic [7:0] ST_OK         = 8'd0;
  localparam logic [7:0] ST_BAD_PROOF  = 8'd1;
  localparam logic [7:0] ST_TABLE_FULL = 8'd2;
  localparam logic [7:0] ST_BAD_NET    = 8'd3;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CHECK  = 3'd1,
    S_LOOKUP = 3'd2,
    S_UPDATE = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] actor;
    logic [31:0] penalty_sum;
    logic [31:0] credit_sum;
  } ledger_entry_t;

  // Unsigned 32-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/xrst_settlement_ingest_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : xrst_sync_fifo
// Description : Single-clock FIFO, power-of-two depth, with full/empty/count.
//               A push while full is accepted only when a pop happens in the
//               same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module xrst_sync_fifo #(
  parameter int WIDTH = 288,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam logic [c_PTR_W:0] c_FULL_CNT = (c_PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_PTR_W:0]   r_count;
  logic               w_full;
  logic               w_do_pop;
  logic               w_do_push;

  assign w_full    = (r_count == c_FULL_CNT);
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && (!w_full || w_do_pop);

  // Storage array: data only, validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (c_PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (c_PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = w_full;
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/xrst_settlement_ingest.sv
`default_nettype none
// ============================================================================
// Module      : xrst_settlement_ingest
// Description : Buffers settlement packets from XRAS, validates proof and net
//               arithmetic, folds accepted amounts into a per-actor ledger and
//               emits one XR-BUS acknowledgement frame per packet.
// Revision    : 1.0 - initial release
// ============================================================================
module xrst_settlement_ingest
  import xrst_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int NUM_ACTORS = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [4095:0]                  settlement_packet,
  input  logic                           packet_valid,
  input  logic [$clog2(NUM_ACTORS)-1:0]  query_idx,
  input  logic                           clr_flags,
  output logic [4095:0]                  xrbus_frame_out,
  output logic                           frame_valid_out,
  output logic [31:0]                    query_actor,
  output logic [31:0]                    query_penalty,
  output logic [31:0]                    query_credit,
  output logic                           query_valid_entry,
  output logic [31:0]                    accepted_count,
  output logic [31:0]                    rejected_count,
  output logic [31:0]                    dropped_count,
  output logic                           overflow,
  output logic                           ingest_busy
);

  localparam int c_IDX_W = $clog2(NUM_ACTORS);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Ingress FIFO
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [c_CNT_W-1:0]   w_fifo_count;
  logic [c_STORE_W-1:0] w_fifo_data;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_unused_pkt_hi;

  // Control and work registers
  state_t               r_state;
  state_t               w_state_next;
  logic [c_STORE_W-1:0] r_work;
  logic [7:0]           r_status;
  logic [c_IDX_W-1:0]   r_idx;
  logic                 r_is_new;
  logic [31:0]          r_balance;

  // Ledger
  ledger_entry_t        r_ledger      [NUM_ACTORS];
  ledger_entry_t        w_ledger_next [NUM_ACTORS];
  ledger_entry_t        w_base;
  ledger_entry_t        w_upd;
  ledger_entry_t        r_query;
  logic                 w_commit;

  // Counters, flags and ack frame
  logic [31:0]          r_accepted;
  logic [31:0]          r_rejected;
  logic [31:0]          r_dropped;
  logic                 r_overflow;
  logic                 r_frame_valid;
  logic [c_PKT_W-1:0]   r_frame;
  logic [c_PKT_W-1:0]   w_frame;

  // Work-register field views
  logic [31:0] w_sid, w_actor, w_pen, w_cred, w_net, w_proof, w_fold;
  logic [7:0]  w_check_status;
  logic                 w_hit, w_free;
  logic [c_IDX_W-1:0]   w_hit_idx, w_free_idx;

  // Bits above the stored window carry nothing for this block.
  assign w_unused_pkt_hi = ^settlement_packet[c_PKT_W-1:c_STORE_W];

  // The FSM only consumes from the FIFO while idle; a full FIFO can still
  // take a new packet in the cycle its head is popped.
  assign w_pop  = (r_state == S_IDLE) && !w_fifo_empty;
  assign w_drop = packet_valid && w_fifo_full && !w_pop;

  xrst_sync_fifo #(
    .WIDTH (c_STORE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (packet_valid),
    .i_data  (settlement_packet[c_STORE_W-1:0]),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_sid   = r_work[c_SID_LSB     +: 32];
  assign w_actor = r_work[c_ACTOR_LSB   +: 32];
  assign w_pen   = r_work[c_PENALTY_LSB +: 32];
  assign w_cred  = r_work[c_CREDIT_LSB  +: 32];
  assign w_net   = r_work[c_NET_LSB     +: 32];
  assign w_proof = r_work[c_PROOF_LSB   +: 32];

  // Compliance checksum: XOR of the eight 32-bit words of the packet body.
  always_comb begin
    w_fold = '0;
    for (int i = 0; i < c_CHK_WORDS; i++) begin
      w_fold = w_fold ^ r_work[i*c_WORD_W +: c_WORD_W];
    end
  end

  // A bad proof takes precedence over bad net arithmetic.
  assign w_check_status = (w_proof != w_fold)         ? ST_BAD_PROOF :
                          (w_net != (w_cred - w_pen)) ? ST_BAD_NET   : ST_OK;

  // Ledger search: matching allocated entry, else lowest free slot.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_free     = 1'b0;
    w_free_idx = '0;
    for (int i = NUM_ACTORS - 1; i >= 0; i--) begin
      if (r_ledger[i].valid && (r_ledger[i].actor == w_actor)) begin
        w_hit     = 1'b1;
        w_hit_idx = c_IDX_W'(i);
      end
      if (!r_ledger[i].valid) begin
        w_free     = 1'b1;
        w_free_idx = c_IDX_W'(i);
      end
    end
  end

  assign w_commit = (r_state == S_UPDATE) && (r_status == ST_OK);

  // Next ledger image; also feeds the query register so a same-cycle update
  // is visible to the read.
  always_comb begin
    w_ledger_next           = r_ledger;
    w_base                  = r_is_new ? '0 : r_ledger[r_idx];
    w_upd                   = w_base;
    w_upd.valid             = 1'b1;
    w_upd.actor             = w_actor;
    w_upd.penalty_sum       = sat_add32(w_base.penalty_sum, w_pen);
    w_upd.credit_sum        = sat_add32(w_base.credit_sum, w_cred);
    if (w_commit) w_ledger_next[r_idx] = w_upd;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next state: fixed five-cycle walk per packet.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (!w_fifo_empty) w_state_next = S_CHECK;
      S_CHECK:  w_state_next = S_LOOKUP;
      S_LOOKUP: w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = S_ACK;
      S_ACK:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Per-packet work registers advanced by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work    <= '0;
      r_status  <= ST_OK;
      r_idx     <= '0;
      r_is_new  <= 1'b0;
      r_balance <= '0;
    end else begin
      case (r_state)
        S_IDLE:  if (w_pop) r_work <= w_fifo_data;
        S_CHECK: r_status <= w_check_status;
        S_LOOKUP: begin
          if (w_hit) begin
            r_idx    <= w_hit_idx;
            r_is_new <= 1'b0;
          end else if (w_free) begin
            r_idx    <= w_free_idx;
            r_is_new <= 1'b1;
          end else if (r_status == ST_OK) begin
            r_status <= ST_TABLE_FULL;
          end
        end
        S_UPDATE: r_balance <= w_commit ? (w_upd.credit_sum - w_upd.penalty_sum) : '0;
        default: ;
      endcase
    end
  end

  // Ledger storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ACTORS; i++) r_ledger[i] <= '0;
    end else begin
      r_ledger <= w_ledger_next;
    end
  end

  // Statistics counters and sticky overflow flag (a new drop beats a clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_accepted <= '0;
      r_rejected <= '0;
      r_dropped  <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_commit) r_accepted <= r_accepted + 32'd1;
      if ((r_state == S_UPDATE) && !w_commit) r_rejected <= r_rejected + 32'd1;
      if (w_drop) r_dropped <= r_dropped + 32'd1;
      if (w_drop)         r_overflow <= 1'b1;
      else if (clr_flags) r_overflow <= 1'b0;
    end
  end

  // Registered ledger read port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_query <= '0;
    else        r_query <= w_ledger_next[query_idx];
  end

  // Ack frame image for the packet currently in ACK.
  always_comb begin
    w_frame = '0;
    w_frame[c_FR_SID_LSB    +: 32] = w_sid;
    w_frame[c_FR_ACTOR_LSB  +: 32] = w_actor;
    w_frame[c_FR_STATUS_LSB +: 8]  = r_status;
    w_frame[c_FR_BAL_LSB    +: 32] = r_balance;
  end

  // Ack output register: frame is forced to zero whenever the strobe is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_valid <= 1'b0;
      r_frame       <= '0;
    end else begin
      r_frame_valid <= (r_state == S_ACK);
      r_frame       <= (r_state == S_ACK) ? w_frame : '0;
    end
  end

  assign xrbus_frame_out   = r_frame;
  assign frame_valid_out   = r_frame_valid;
  assign query_actor       = r_query.actor;
  assign query_penalty     = r_query.penalty_sum;
  assign query_credit      = r_query.credit_sum;
  assign query_valid_entry = r_query.valid;
  assign accepted_count    = r_accepted;
  assign rejected_count    = r_rejected;
  assign dropped_count     = r_dropped;
  assign overflow          = r_overflow;
  assign ingest_busy       = (r_state != S_IDLE) || (w_fifo_count != '0);

endmodule
`default_nettype wire

// File: tb/tb_xrst_settlement_ingest.sv
`default_nettype none
// ============================================================================
// Module      : tb_xrst_settlement_ingest
// Description : Self-checking bench for xrst_settlement_ingest with directed
//               scenarios plus randomized packets against a ledger model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_xrst_settlement_ingest;

  localparam int FIFO_DEPTH = 4;
  localparam int NUM_ACTORS = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [4095:0] settlement_packet;
  logic          packet_valid;
  logic [2:0]    query_idx;
  logic          clr_flags;
  logic [4095:0] xrbus_frame_out;
  logic          frame_valid_out;
  logic [31:0]   query_actor, query_penalty, query_credit;
  logic          query_valid_entry;
  logic [31:0]   accepted_count, rejected_count, dropped_count;
  logic          overflow, ingest_busy;

  xrst_settlement_ingest #(.FIFO_DEPTH(FIFO_DEPTH), .NUM_ACTORS(NUM_ACTORS)) dut (
    .clk(clk), .rst_n(rst_n), .settlement_packet(settlement_packet),
    .packet_valid(packet_valid), .query_idx(query_idx), .clr_flags(clr_flags),
    .xrbus_frame_out(xrbus_frame_out), .frame_valid_out(frame_valid_out),
    .query_actor(query_actor), .query_penalty(query_penalty),
    .query_credit(query_credit), .query_valid_entry(query_valid_entry),
    .accepted_count(accepted_count), .rejected_count(rejected_count),
    .dropped_count(dropped_count), .overflow(overflow), .ingest_busy(ingest_busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] sid;
    logic [31:0] actor;
    logic [7:0]  status;
    logic [31:0] bal;
    int          push_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic        m_valid [NUM_ACTORS];
  logic [31:0] m_actor [NUM_ACTORS];
  logic [31:0] m_pen   [NUM_ACTORS];
  logic [31:0] m_cred  [NUM_ACTORS];
  logic [31:0] m_acc, m_rej;
  logic [31:0] sid_n = 32'd1;

  int          ack_count = 0;
  int          last_ack_lat = 0;
  logic [7:0]  last_status = 8'hFF;
  logic [31:0] last_bal = 32'h0;
  exp_t        mon_e;

  function automatic logic [31:0] fold(input logic [4095:0] p);
    logic [31:0] x = 32'h0;
    for (int i = 0; i < 8; i++) x ^= p[i*32 +: 32];
    return x;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_ACTORS; i++) begin
      m_valid[i] = 1'b0; m_actor[i] = '0; m_pen[i] = '0; m_cred[i] = '0;
    end
    m_acc = '0; m_rej = '0;
  endtask

  task automatic model_apply(input logic [4095:0] p, output exp_t e);
    logic [31:0] actor, pen, cred, net;
    int slot;
    longint s;
    actor = p[95:64]; pen = p[127:96]; cred = p[159:128]; net = p[191:160];
    e.sid = p[31:0]; e.actor = actor; e.bal = '0; e.push_cyc = 0;
    slot = -1;
    if (p[287:256] != fold(p))  e.status = 8'd1;
    else if (net != cred - pen) e.status = 8'd3;
    else begin
      for (int i = 0; i < NUM_ACTORS; i++) if (m_valid[i] && m_actor[i] == actor) slot = i;
      if (slot < 0) for (int i = NUM_ACTORS - 1; i >= 0; i--) if (!m_valid[i]) slot = i;
      e.status = (slot < 0) ? 8'd2 : 8'd0;
    end
    if (e.status == 8'd0) begin
      m_valid[slot] = 1'b1;
      m_actor[slot] = actor;
      s = longint'(m_pen[slot]) + longint'(pen);
      m_pen[slot] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      s = longint'(m_cred[slot]) + longint'(cred);
      m_cred[slot] = (s > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
      e.bal = m_cred[slot] - m_pen[slot];
      m_acc = m_acc + 1;
    end else begin
      m_rej = m_rej + 1;
    end
  endtask

  function automatic logic [4095:0] mk_pkt(input logic [31:0] actor, input logic [31:0] pen,
                                           input logic [31:0] cred, input logic [31:0] net,
                                           input bit corrupt);
    logic [4095:0] p;
    logic [31:0]   flip;
    for (int i = 0; i < 128; i++) p[i*32 +: 32] = $urandom;
    p[31:0]    = sid_n;
    sid_n      = sid_n + 1;
    p[95:64]   = actor;
    p[127:96]  = pen;
    p[159:128] = cred;
    p[191:160] = net;
    flip = corrupt ? (32'h1 << $urandom_range(0, 31)) : 32'h0;
    p[287:256] = fold(p) ^ flip;
    return p;
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called at a falling edge; drives a one-cycle strobe and returns at the next falling edge.
  task automatic pulse(input logic [4095:0] p, input bit expect_ack);
    exp_t e;
    if (expect_ack) begin
      model_apply(p, e);
      e.push_cyc = cyc + 1;
      exp_q.push_back(e);
    end
    settlement_packet = p;
    packet_valid = 1'b1;
    @(negedge clk);
    packet_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic q_read(input int idx);
    @(negedge clk);
    query_idx = 3'(idx);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; packet_valid = 1'b0; clr_flags = 1'b0;
    repeat (2) @(negedge clk);
    exp_q.delete();
    model_reset();
    rst_n = 1'b1;
  endtask

  // Ack monitor: every frame is matched in order against the model's queue.
  always @(negedge clk) begin
    if (frame_valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_ack", 64'(frame_valid_out), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("ack_sid",    64'(xrbus_frame_out[31:0]),  64'(mon_e.sid));
        check("ack_actor",  64'(xrbus_frame_out[63:32]), 64'(mon_e.actor));
        check("ack_status", 64'(xrbus_frame_out[71:64]), 64'(mon_e.status));
        check("ack_bal",    64'(xrbus_frame_out[103:72]), 64'(mon_e.bal));
        check("ack_hi_zero", 64'(|xrbus_frame_out[4095:104]), 64'd0);
        last_ack_lat = cyc - mon_e.push_cyc;
        last_status  = xrbus_frame_out[71:64];
        last_bal     = xrbus_frame_out[103:72];
        ack_count++;
      end
    end else if (rst_n) begin
      check("frame_idle_zero", 64'(|xrbus_frame_out), 64'd0);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  logic [31:0] pool [8];
  int          base_acks;

  initial begin
    rst_n = 1'b0; packet_valid = 1'b0; clr_flags = 1'b0; query_idx = '0;
    settlement_packet = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_frame_valid", 64'(frame_valid_out), 64'd0);
    check("rst_frame",       64'(|xrbus_frame_out), 64'd0);
    check("rst_accepted",    64'(accepted_count), 64'd0);
    check("rst_dropped",     64'(dropped_count), 64'd0);
    check("rst_overflow",    64'(overflow), 64'd0);
    check("rst_busy",        64'(ingest_busy), 64'd0);
    check("rst_qvalid",      64'(query_valid_entry), 64'd0);
    rst_n = 1'b1;

    // New actor, valid packet
    @(negedge clk);
    pulse(mk_pkt(32'h11, 32'd50, 32'd200, 32'd150, 1'b0), 1'b1);
    drain(30);
    check("t1_latency", 64'(last_ack_lat), 64'd5);
    check("t1_status",  64'(last_status), 64'd0);
    check("t1_bal",     64'(last_bal), 64'd150);
    check("t1_accepted", 64'(accepted_count), 64'd1);
    q_read(0);
    check("t1_q_actor", 64'(query_actor), 64'h11);
    check("t1_q_pen",   64'(query_penalty), 64'd50);
    check("t1_q_cred",  64'(query_credit), 64'd200);
    check("t1_q_valid", 64'(query_valid_entry), 64'd1);

    // Same actor; query of entry 0 is held to observe read-after-write
    @(negedge clk);
    pulse(mk_pkt(32'h11, 32'd30, 32'd0, 32'hFFFF_FFE2, 1'b0), 1'b1);
    repeat (4) @(negedge clk);
    check("t2_raw_pen", 64'(query_penalty), 64'd80);
    drain(30);
    check("t2_latency", 64'(last_ack_lat), 64'd5);
    check("t2_status",  64'(last_status), 64'd0);
    check("t2_bal",     64'(last_bal), 64'd120);
    q_read(1);
    check("t2_no_new_entry", 64'(query_valid_entry), 64'd0);

    // Corrupted proof word
    @(negedge clk);
    pulse(mk_pkt(32'h11, 32'd50, 32'd200, 32'd150, 1'b1), 1'b1);
    drain(30);
    check("t3_status",   64'(last_status), 64'd1);
    check("t3_bal",      64'(last_bal), 64'd0);
    check("t3_rejected", 64'(rejected_count), 64'd1);
    q_read(0);
    check("t3_q_pen",  64'(query_penalty), 64'd80);
    check("t3_q_cred", 64'(query_credit), 64'd200);

    // Net mismatch
    @(negedge clk);
    pulse(mk_pkt(32'h11, 32'd50, 32'd200, 32'd100, 1'b0), 1'b1);
    drain(30);
    check("t4_status",   64'(last_status), 64'd3);
    check("t4_rejected", 64'(rejected_count), 64'd2);
    check("t4_accepted", 64'(accepted_count), 64'd2);

    // Nine distinct actors into an eight-entry ledger
    do_reset();
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      pulse(mk_pkt(32'h100 + 32'(i), 32'(i + 1), 32'd100, 32'd99 - 32'(i), 1'b0), 1'b1);
      repeat (5) @(negedge clk);
    end
    drain(40);
    check("t5_last_status", 64'(last_status), 64'd2);
    check("t5_accepted",    64'(accepted_count), 64'd8);
    check("t5_rejected",    64'(rejected_count), 64'd1);

    // Six back-to-back strobes into a four-deep FIFO
    do_reset();
    base_acks = ack_count;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      pulse(mk_pkt(32'h200 + 32'(i), 32'(i), 32'd10, 32'd10 - 32'(i), 1'b0), i < 5);
    end
    drain(80);
    repeat (12) @(negedge clk);
    check("t6_acks",     64'(ack_count - base_acks), 64'd5);
    check("t6_dropped",  64'(dropped_count), 64'd1);
    check("t6_overflow", 64'(overflow), 64'd1);
    check("t6_accepted", 64'(accepted_count), 64'd5);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("t6_ovf_clr",     64'(overflow), 64'd0);
    check("t6_dropped_kept", 64'(dropped_count), 64'd1);

    // Penalty saturation
    do_reset();
    @(negedge clk);
    pulse(mk_pkt(32'h33, 32'hFFFF_FFF0, 32'd0, 32'h10, 1'b0), 1'b1);
    drain(30);
    @(negedge clk);
    pulse(mk_pkt(32'h33, 32'h20, 32'd0, 32'hFFFF_FFE0, 1'b0), 1'b1);
    drain(30);
    q_read(0);
    check("t7_sat_pen", 64'(query_penalty), 64'hFFFF_FFFF);
    check("t7_bal",     64'(last_bal), 64'd1);

    // Randomized traffic from an eight-actor pool
    do_reset();
    for (int i = 0; i < 8; i++) pool[i] = ($urandom & 32'hFFFF_FF00) | 32'(i);
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a, pen, cred, net;
      int kind;
      a    = pool[$urandom_range(0, 7)];
      pen  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      cred = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1000));
      net  = cred - pen;
      kind = $urandom_range(0, 9);
      if (kind == 7 || kind == 8) net = net ^ (32'h1 << $urandom_range(0, 31));
      repeat ($urandom_range(4, 7)) @(negedge clk);
      pulse(mk_pkt(a, pen, cred, net, kind == 9), 1'b1);
    end
    drain(60);
    check("rnd_accepted", 64'(accepted_count), 64'(m_acc));
    check("rnd_rejected", 64'(rejected_count), 64'(m_rej));
    check("rnd_dropped",  64'(dropped_count), 64'd0);
    for (int i = 0; i < NUM_ACTORS; i++) begin
      q_read(i);
      check("rnd_q_valid", 64'(query_valid_entry), 64'(m_valid[i]));
      if (m_valid[i]) begin
        check("rnd_q_actor", 64'(query_actor), 64'(m_actor[i]));
        check("rnd_q_pen",   64'(query_penalty), 64'(m_pen[i]));
        check("rnd_q_cred",  64'(query_credit), 64'(m_cred[i]));
      end
    end

    // Reset while a packet sits in CHECK
    @(negedge clk);
    pulse(mk_pkt(pool[0], 32'd1, 32'd2, 32'd1, 1'b0), 1'b0);
    @(negedge clk);
    check("t8_busy_mid", 64'(ingest_busy), 64'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    base_acks = ack_count;
    repeat (15) @(negedge clk);
    check("t8_no_ack",   64'(ack_count - base_acks), 64'd0);
    check("t8_accepted", 64'(accepted_count), 64'd0);
    check("t8_rejected", 64'(rejected_count), 64'd0);
    check("t8_dropped",  64'(dropped_count), 64'd0);
    check("t8_busy",     64'(ingest_busy), 64'd0);
    for (int i = 0; i < NUM_ACTORS; i++) begin
      q_read(i);
      check("t8_q_valid", 64'(query_valid_entry), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
